// File: rtl/axis_framer_pkg.sv
// rtl/axis_framer_pkg.sv - shared state encoding for the stream framer
package axis_framer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HEAD = ST_HEAD,
    DATA = ST_DATA,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/axis_framer_oreg.sv
// rtl/axis_framer_oreg.sv - single-entry output register with valid/ready handshake
module axis_framer_oreg #(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        load,
  input  logic [AXIS_TDATA_WIDTH-1:0] load_data,
  input  logic                        load_last,
  output logic                        free,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);

  // The register may be refilled in the same cycle it is drained.
  assign free = ~m_axis_tvalid | m_axis_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= load_data;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= load_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_framer.sv
// rtl/axis_framer.sv - cuts a stream into fixed-length packets with optional header beat
module axis_framer
  import axis_framer_pkg::*;
#(
  parameter int    AXIS_TDATA_WIDTH = 32,
  parameter int    CNTR_WIDTH       = 32,
  parameter int    PCKT_WIDTH       = 16,
  parameter string HEADER           = "FALSE"
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  input  logic [PCKT_WIDTH-1:0]       cfg_pckt,
  input  logic                        cfg_start,
  output logic [PCKT_WIDTH-1:0]       sts_pckt,
  output logic                        sts_busy,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);

  localparam bit HAS_HEADER = (HEADER == "TRUE");

  state_t                        state, state_nxt;
  logic [CNTR_WIDTH-1:0]         word_cnt, data_len;
  logic [PCKT_WIDTH-1:0]         pckt_cnt, pckt_lim, pckt_inc;
  logic                          free, accept, word_last;
  logic                          load, load_last;
  logic [AXIS_TDATA_WIDTH-1:0]   load_data, head_data;

  assign pckt_inc      = pckt_cnt + PCKT_WIDTH'(1);
  assign s_axis_tready = (state == DATA) & free;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign word_last     = (word_cnt == data_len);
  assign sts_busy      = (state == HEAD) | (state == DATA);
  assign sts_pckt      = pckt_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_data = s_axis_tdata;
    load_last = 1'b0;
    head_data = '0;
    head_data[PCKT_WIDTH-1:0] = pckt_cnt;
    case (state)
      IDLE: if (cfg_start) state_nxt = HAS_HEADER ? HEAD : DATA;
      HEAD: if (free) begin
        load      = 1'b1;
        load_data = head_data;
        state_nxt = DATA;
      end
      DATA: if (accept) begin
        load      = 1'b1;
        load_last = word_last;
        // End-of-run is judged on the count including the packet just closed.
        if (word_last) begin
          if (((pckt_lim != '0) && (pckt_inc == pckt_lim)) || !cfg_start) state_nxt = DONE;
          else if (HAS_HEADER)                                           state_nxt = HEAD;
        end
      end
      DONE: if (!m_axis_tvalid && !cfg_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      word_cnt <= '0;
      data_len <= '0;
      pckt_cnt <= '0;
      pckt_lim <= '0;
    end else if (state == IDLE && cfg_start) begin
      data_len <= cfg_data;
      pckt_lim <= cfg_pckt;
      word_cnt <= '0;
      pckt_cnt <= '0;
    end else if (accept) begin
      if (word_last) begin
        word_cnt <= '0;
        pckt_cnt <= pckt_inc;
      end else begin
        word_cnt <= word_cnt + CNTR_WIDTH'(1);
      end
    end
  end

  axis_framer_oreg #(
    .AXIS_TDATA_WIDTH(AXIS_TDATA_WIDTH)
  ) u_oreg (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .load          (load),
    .load_data     (load_data),
    .load_last     (load_last),
    .free          (free),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast)
  );

endmodule

// File: tb/tb_axis_framer.sv
// tb/tb_axis_framer.sv - scoreboard bench for axis_framer without and with header beats
module tb_axis_framer;
  import axis_framer_pkg::*;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;

  logic [31:0] cfg_data_a, cfg_data_b;
  logic [15:0] cfg_pckt_a, cfg_pckt_b;
  logic        cfg_start_a, cfg_start_b;
  logic [15:0] sts_pckt_a, sts_pckt_b;
  logic        sts_busy_a, sts_busy_b;
  logic        s_tready_a, s_tready_b, s_tvalid_a, s_tvalid_b;
  logic [31:0] s_tdata_a, s_tdata_b, m_tdata_a, m_tdata_b;
  logic        m_tready_a, m_tready_b, m_tvalid_a, m_tvalid_b, m_tlast_a, m_tlast_b;

  axis_framer u_a (
    .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg_data_a), .cfg_pckt(cfg_pckt_a),
    .cfg_start(cfg_start_a), .sts_pckt(sts_pckt_a), .sts_busy(sts_busy_a),
    .s_axis_tready(s_tready_a), .s_axis_tdata(s_tdata_a), .s_axis_tvalid(s_tvalid_a),
    .m_axis_tready(m_tready_a), .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a),
    .m_axis_tlast(m_tlast_a)
  );

  axis_framer #(.HEADER("TRUE")) u_b (
    .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg_data_b), .cfg_pckt(cfg_pckt_b),
    .cfg_start(cfg_start_b), .sts_pckt(sts_pckt_b), .sts_busy(sts_busy_b),
    .s_axis_tready(s_tready_b), .s_axis_tdata(s_tdata_b), .s_axis_tvalid(s_tvalid_b),
    .m_axis_tready(m_tready_b), .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b),
    .m_axis_tlast(m_tlast_b)
  );

  int          checks = 0;
  int          fails  = 0;
  int          src_waits;
  logic [32:0] exp_a[$];
  logic [32:0] exp_b[$];
  logic        bp_en = 1'b0;
  logic        stall_a = 1'b0;
  logic [33:0] held_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    fails++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Expected beat is queued as the word is offered; the DUT preserves order.
  task automatic send(input bit b, input logic [31:0] d, input bit last);
    int n = 0;
    if (b) begin
      exp_b.push_back({last, d});
      s_tdata_b = d; s_tvalid_b = 1'b1;
    end else begin
      exp_a.push_back({last, d});
      s_tdata_a = d; s_tvalid_a = 1'b1;
    end
    @(negedge aclk);
    while (!(b ? s_tready_b : s_tready_a) && n < 50) begin
      n++;
      @(negedge aclk);
    end
    if (n == 50) fail_now("send_timeout", "input beat not accepted within 50 cycles");
    src_waits += n;
    tick();
    if (b) s_tvalid_b = 1'b0;
    else   s_tvalid_a = 1'b0;
  endtask

  task automatic wait_drain(input bit b);
    int n = 0;
    while ((b ? exp_b.size() : exp_a.size()) != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain", b ? exp_b.size() : exp_a.size(), 0);
    tick();
  endtask

  initial begin
    m_tready_a = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_tready_a = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge aclk) begin
    if (stall_a && aresetn) check("stall_stable", {m_tvalid_a, m_tlast_a, m_tdata_a}, held_a);
    stall_a <= aresetn & m_tvalid_a & ~m_tready_a;
    held_a  <= {m_tvalid_a, m_tlast_a, m_tdata_a};
    if (aresetn && m_tvalid_a && m_tready_a) begin
      if (exp_a.size() == 0) fail_now("spurious_a", "output beat with empty scoreboard");
      else check("beat_a", {m_tlast_a, m_tdata_a}, exp_a.pop_front());
    end
  end

  always @(negedge aclk) begin
    if (aresetn && m_tvalid_b && m_tready_b) begin
      if (exp_b.size() == 0) fail_now("spurious_b", "output beat with empty scoreboard");
      else check("beat_b", {m_tlast_b, m_tdata_b}, exp_b.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    cfg_data_a = '0; cfg_pckt_a = '0; cfg_start_a = 1'b0; s_tdata_a = '0; s_tvalid_a = 1'b0;
    cfg_data_b = '0; cfg_pckt_b = '0; cfg_start_b = 1'b0; s_tdata_b = '0; s_tvalid_b = 1'b0;
    m_tready_b = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", m_tvalid_a, 0);
    check("rst_tlast", m_tlast_a, 0);
    check("rst_tdata", m_tdata_a, 0);
    check("rst_s_tready", s_tready_a, 0);
    check("rst_busy", sts_busy_a, 0);
    check("rst_pckt", sts_pckt_a, 0);
    aresetn = 1'b1;
    repeat (3) tick();
    check("idle_hold", 64'(u_a.state), 64'(IDLE));

    // 4-word packets, 2 packets, no backpressure
    cfg_data_a = 3; cfg_pckt_a = 2; cfg_start_a = 1'b1;
    tick();
    src_waits = 0;
    for (int i = 0; i < 8; i++) send(0, 32'h100 + i, (i % 4) == 3);
    check("t1_full_rate", src_waits, 0);
    check("t1_s_tready_done", s_tready_a, 0);
    wait_drain(0);
    check("t1_pckt", sts_pckt_a, 2);
    check("t1_state", 64'(u_a.state), 64'(DONE));
    check("t1_busy", sts_busy_a, 0);
    cfg_start_a = 1'b0;
    repeat (2) tick();
    check("t1_idle", 64'(u_a.state), 64'(IDLE));
    check("t1_pckt_hold", sts_pckt_a, 2);

    // header variant: H0,d,d,H1,d,d,H2,d,d
    cfg_data_b = 1; cfg_pckt_b = 3; cfg_start_b = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      exp_b.push_back({1'b0, 32'(p)});
      send(1, 32'h200 + 32'(2 * p), 1'b0);
      send(1, 32'h201 + 32'(2 * p), 1'b1);
    end
    wait_drain(1);
    check("hdr_pckt", sts_pckt_b, 3);
    check("hdr_state", 64'(u_b.state), 64'(DONE));
    cfg_start_b = 1'b0;
    repeat (2) tick();

    // unlimited run, start dropped inside packet 5
    cfg_data_a = 1; cfg_pckt_a = 0; cfg_start_a = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      send(0, 32'h300 + i, (i % 2) == 1);
      if (i == 8) cfg_start_a = 1'b0;
    end
    wait_drain(0);
    tick();
    check("stop_pckt", sts_pckt_a, 5);
    check("stop_busy", sts_busy_a, 0);
    check("stop_idle", 64'(u_a.state), 64'(IDLE));
    check("stop_s_tready", s_tready_a, 0);

    // random backpressure, 3-word packets
    bp_en = 1'b1;
    cfg_data_a = 2; cfg_pckt_a = 3; cfg_start_a = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) send(0, 32'hA500_0000 + 32'(i * 37), (i % 3) == 2);
    wait_drain(0);
    bp_en = 1'b0;
    tick();
    check("bp_pckt", sts_pckt_a, 3);
    check("bp_state", 64'(u_a.state), 64'(DONE));
    cfg_start_a = 1'b0;
    repeat (2) tick();

    // single-word packets; cfg_data change mid-run applies only to next run
    cfg_data_a = 0; cfg_pckt_a = 3; cfg_start_a = 1'b1;
    tick();
    cfg_data_a = 5;
    for (int i = 0; i < 3; i++) send(0, 32'h400 + i, 1'b1);
    wait_drain(0);
    check("one_pckt", sts_pckt_a, 3);
    check("one_state", 64'(u_a.state), 64'(DONE));
    cfg_start_a = 1'b0;
    repeat (2) tick();
    cfg_pckt_a = 1; cfg_start_a = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) send(0, 32'h500 + i, i == 5);
    wait_drain(0);
    check("next_run_pckt", sts_pckt_a, 1);
    cfg_start_a = 1'b0;
    repeat (2) tick();

    // reset in the middle of packet 2
    cfg_data_a = 3; cfg_pckt_a = 0; cfg_start_a = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) send(0, 32'h600 + i, i == 3);
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", m_tvalid_a, 0);
    check("mid_rst_pckt", sts_pckt_a, 0);
    check("mid_rst_busy", sts_busy_a, 0);
    exp_a.delete();
    cfg_start_a = 1'b0;
    tick();
    aresetn = 1'b1;
    repeat (2) tick();
    check("post_rst_idle", 64'(u_a.state), 64'(IDLE));
    check("post_rst_tvalid", m_tvalid_a, 0);
    cfg_pckt_a = 1; cfg_start_a = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(0, 32'h700 + i, i == 3);
    wait_drain(0);
    check("post_rst_pckt", sts_pckt_a, 1);
    cfg_start_a = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
